// File: rtl/vga_timing_axis_counter_if.sv
// Scan-axis counter bus: count enable in, position/region/strobe outputs back.
`timescale 1ns/1ps
interface vga_timing_axis_counter_if #(
    parameter int COUNTER_SIZE = 11
);
    logic                    count_enable;
    logic [COUNTER_SIZE-1:0] counter_status;
    logic [1:0]              region;
    logic                    active;
    logic                    sync;
    logic                    zero_detected;
    logic                    threshold_detected;
    logic                    end_of_period;
    logic                    carry_out;

    modport slave (
        input  count_enable,
        output counter_status, region, active, sync, zero_detected,
               threshold_detected, end_of_period, carry_out
    );

    modport master (
        output count_enable,
        input  counter_status, region, active, sync, zero_detected,
               threshold_detected, end_of_period, carry_out
    );
endinterface

// File: rtl/vga_timing_axis_counter.sv
// One VGA scan axis: wrapping position counter with region FSM and decoded strobes.
// Cascade two instances (horizontal carry_out -> vertical count_enable) for a raster.
//
//   state     | meaning
//   ST_ACTIVE | visible samples, active=1
//   ST_FRONT  | front porch
//   ST_SYNC   | sync pulse asserted
//   ST_BACK   | back porch, wraps to ST_ACTIVE
`timescale 1ns/1ps
module vga_timing_axis_counter #(
    parameter int COUNTER_SIZE     = 11,
    parameter int ACTIVE_LEN       = 1024,
    parameter int FRONT_LEN        = 24,
    parameter int SYNC_LEN         = 136,
    parameter int BACK_LEN         = 144,
    parameter bit SYNC_ACTIVE_HIGH = 1'b0,
    parameter int THRESHOLD        = 1024
) (
    input  logic                            control_clock,
    input  logic                            control_reset_n,
    vga_timing_axis_counter_if.slave        axis
);
    localparam int TOTAL = ACTIVE_LEN + FRONT_LEN + SYNC_LEN + BACK_LEN;

    if (ACTIVE_LEN < 1 || FRONT_LEN < 1 || SYNC_LEN < 1 || BACK_LEN < 1 ||
        longint'(TOTAL) > (longint'(1) << COUNTER_SIZE) ||
        THRESHOLD < 0 || THRESHOLD >= TOTAL) begin : g_param_check
        $error("vga_timing_axis_counter: illegal region lengths, counter width or threshold");
    end

    localparam logic [COUNTER_SIZE-1:0] FRONT_START = COUNTER_SIZE'(ACTIVE_LEN);
    localparam logic [COUNTER_SIZE-1:0] SYNC_START  = COUNTER_SIZE'(ACTIVE_LEN + FRONT_LEN);
    localparam logic [COUNTER_SIZE-1:0] BACK_START  = COUNTER_SIZE'(ACTIVE_LEN + FRONT_LEN + SYNC_LEN);
    localparam logic [COUNTER_SIZE-1:0] LAST_COUNT  = COUNTER_SIZE'(TOTAL - 1);
    localparam logic [COUNTER_SIZE-1:0] THRESH_VAL  = COUNTER_SIZE'(THRESHOLD);
    localparam bit                      THRESH_AT_0 = (THRESHOLD == 0);

    localparam logic [1:0] ST_ACTIVE = 2'd0;
    localparam logic [1:0] ST_FRONT  = 2'd1;
    localparam logic [1:0] ST_SYNC   = 2'd2;
    localparam logic [1:0] ST_BACK   = 2'd3;

    logic [COUNTER_SIZE-1:0] count_q, count_d;
    logic [1:0]              region_q, region_d;
    logic                    active_q, sync_q, zero_q, thresh_q, eop_q;

    // Region follows the next count so it never lags counter_status.
    always_comb begin
        count_d  = count_q;
        region_d = region_q;
        if (axis.count_enable) begin
            count_d = (count_q == LAST_COUNT) ? '0 : count_q + COUNTER_SIZE'(1);
            case (region_q)
                ST_ACTIVE: if (count_d == FRONT_START) region_d = ST_FRONT;
                ST_FRONT:  if (count_d == SYNC_START)  region_d = ST_SYNC;
                ST_SYNC:   if (count_d == BACK_START)  region_d = ST_BACK;
                default:   if (count_d == '0)         region_d = ST_ACTIVE;
            endcase
        end
    end

    always_ff @(posedge control_clock or negedge control_reset_n) begin
        if (!control_reset_n) begin
            count_q  <= '0;
            region_q <= ST_ACTIVE;
            active_q <= 1'b1;
            sync_q   <= ~SYNC_ACTIVE_HIGH;
            zero_q   <= 1'b1;
            thresh_q <= THRESH_AT_0;
            eop_q    <= 1'b0;
        end else begin
            count_q  <= count_d;
            region_q <= region_d;
            active_q <= (region_d == ST_ACTIVE);
            sync_q   <= (region_d == ST_SYNC) ? SYNC_ACTIVE_HIGH : ~SYNC_ACTIVE_HIGH;
            zero_q   <= (count_d == '0);
            thresh_q <= (count_d == THRESH_VAL);
            eop_q    <= (count_d == LAST_COUNT);
        end
    end

    assign axis.counter_status     = count_q;
    assign axis.region             = region_q;
    assign axis.active             = active_q;
    assign axis.sync               = sync_q;
    assign axis.zero_detected      = zero_q;
    assign axis.threshold_detected = thresh_q;
    assign axis.end_of_period      = eop_q;
    // Only combinational output: lets a downstream axis step on this axis's wrap edge.
    assign axis.carry_out          = eop_q & axis.count_enable;
endmodule

// File: tb/tb_vga_timing_axis_counter.sv
// Scoreboard bench: three axis counters (TOTAL=8 horizontal, cascaded TOTAL=5 vertical,
// all-length-1 axis) against a range-based reference model.
`timescale 1ns/1ps
module tb_vga_timing_axis_counter;
    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    vga_timing_axis_counter_if #(.COUNTER_SIZE(4)) a_if ();
    vga_timing_axis_counter_if #(.COUNTER_SIZE(3)) v_if ();
    vga_timing_axis_counter_if #(.COUNTER_SIZE(2)) m_if ();

    assign v_if.count_enable = a_if.carry_out;

    vga_timing_axis_counter #(.COUNTER_SIZE(4), .ACTIVE_LEN(4), .FRONT_LEN(1), .SYNC_LEN(2),
        .BACK_LEN(1), .SYNC_ACTIVE_HIGH(1'b0), .THRESHOLD(5)) u_a (
        .control_clock(clk), .control_reset_n(rst_n), .axis(a_if));
    vga_timing_axis_counter #(.COUNTER_SIZE(3), .ACTIVE_LEN(2), .FRONT_LEN(1), .SYNC_LEN(1),
        .BACK_LEN(1), .SYNC_ACTIVE_HIGH(1'b1), .THRESHOLD(4)) u_v (
        .control_clock(clk), .control_reset_n(rst_n), .axis(v_if));
    vga_timing_axis_counter #(.COUNTER_SIZE(2), .ACTIVE_LEN(1), .FRONT_LEN(1), .SYNC_LEN(1),
        .BACK_LEN(1), .SYNC_ACTIVE_HIGH(1'b1), .THRESHOLD(3)) u_m (
        .control_clock(clk), .control_reset_n(rst_n), .axis(m_if));

    typedef struct {
        int cnt; int rgn; bit act; bit syn; bit zero; bit thr; bit eop; bit cy;
    } exp_t;
    typedef struct { exp_t a; exp_t v; exp_t m; } exp_row_t;

    exp_row_t sb_q[$];
    int pushed = 0, popped = 0;
    int checks = 0, errors = 0;
    int ma = 0, mv = 0, mm = 0;

    function automatic exp_t predict(int cnt, bit en, int al, int fl, int sl, int bl,
                                     int thr, bit sah);
        exp_t e;
        int total = al + fl + sl + bl;
        e.cnt  = cnt;
        e.rgn  = (cnt < al) ? 0 : (cnt < al + fl) ? 1 : (cnt < al + fl + sl) ? 2 : 3;
        e.act  = (e.rgn == 0);
        e.syn  = (e.rgn == 2) ? sah : !sah;
        e.zero = (cnt == 0);
        e.thr  = (cnt == thr);
        e.eop  = (cnt == total - 1);
        e.cy   = e.eop && en;
        return e;
    endfunction

    task automatic issue(input bit en);
        exp_row_t r;
        a_if.count_enable = en;
        m_if.count_enable = en;
        r.a = predict(ma, en, 4, 1, 2, 1, 5, 1'b0);
        r.v = predict(mv, r.a.cy, 2, 1, 1, 1, 4, 1'b1);
        r.m = predict(mm, en, 1, 1, 1, 1, 3, 1'b1);
        sb_q.push_back(r);
        pushed++;
        if (rst_n) begin
            if (r.a.cy) mv = (mv + 1) % 5;
            if (en) begin
                ma = (ma + 1) % 8;
                mm = (mm + 1) % 4;
            end
        end
    endtask

    task automatic step(input bit en);
        @(negedge clk);
        issue(en);
    endtask

    task automatic cmp(input string nm, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic check_inst(input string p, input exp_t e, input int cnt, input int rgn,
                              input int act, input int syn, input int zero, input int thr,
                              input int eop, input int cy);
        cmp({p, ".counter_status"}, cnt, e.cnt);
        cmp({p, ".region"}, rgn, e.rgn);
        cmp({p, ".active"}, act, int'(e.act));
        cmp({p, ".sync"}, syn, int'(e.syn));
        cmp({p, ".zero_detected"}, zero, int'(e.zero));
        cmp({p, ".threshold_detected"}, thr, int'(e.thr));
        cmp({p, ".end_of_period"}, eop, int'(e.eop));
        cmp({p, ".carry_out"}, cy, int'(e.cy));
    endtask

    initial begin : monitor
        exp_row_t r;
        forever begin
            wait (pushed > popped);
            #1;
            r = sb_q.pop_front();
            popped++;
            check_inst("h", r.a, int'(a_if.counter_status), int'(a_if.region),
                int'(a_if.active), int'(a_if.sync), int'(a_if.zero_detected),
                int'(a_if.threshold_detected), int'(a_if.end_of_period), int'(a_if.carry_out));
            check_inst("v", r.v, int'(v_if.counter_status), int'(v_if.region),
                int'(v_if.active), int'(v_if.sync), int'(v_if.zero_detected),
                int'(v_if.threshold_detected), int'(v_if.end_of_period), int'(v_if.carry_out));
            check_inst("m", r.m, int'(m_if.counter_status), int'(m_if.region),
                int'(m_if.active), int'(m_if.sync), int'(m_if.zero_detected),
                int'(m_if.threshold_detected), int'(m_if.end_of_period), int'(m_if.carry_out));
        end
    end

    initial begin : stimulus
        a_if.count_enable = 1'b0;
        m_if.count_enable = 1'b0;
        rst_n = 1'b0;
        #2;
        for (int i = 0; i < 3; i++) step(1'(($urandom_range(0, 1))));

        @(negedge clk);
        rst_n = 1'b1;
        issue(1'b1);
        for (int i = 0; i < 19; i++) step(1'b1);

        for (int i = 0; i < 16; i++) step(1'(i % 2 == 0));

        for (int i = 0; i < 300; i++) step(1'(($urandom_range(0, 3) != 0)));

        for (int i = 0; i < 20 && ma != 6; i++) step(1'b1);
        @(negedge clk);
        issue(1'b1);
        #3;
        rst_n = 1'b0;
        ma = 0; mv = 0; mm = 0;
        issue(1'b1);
        step(1'b1);
        step(1'b0);
        @(negedge clk);
        rst_n = 1'b1;
        issue(1'b1);
        for (int i = 0; i < 44; i++) step(1'b1);

        @(negedge clk);
        a_if.count_enable = 1'b0;
        m_if.count_enable = 1'b0;
        for (int i = 0; i < 10 && popped < pushed; i++) @(negedge clk);
        checks++;
        if (popped != pushed) begin
            errors++;
            $display("FAIL scoreboard_drain: got %0d popped expected %0d", popped, pushed);
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
